uart_tx_arbiter: RTL

Packet-granular round-robin arbiter that shares the single `uart_tx` transmitter among `NUM_REQ` byte-stream requesters, such as the monitor read-response path and telemetry sources. It sits between the requesters and `uart_tx`. It owns `tx_write`/`tx_byte` and sequences one byte at a time against `tx_busy`. Once a requester is granted, it keeps the transmitter until it presents its `last` byte.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter: state encoding and default sizing.
package uart_tx_arbiter_pkg;

  localparam int UART_ARB_STATES_NUM     = 5;
  localparam int UART_ARB_NUM_REQ        = 4;
  localparam int UART_ARB_DATA_BITS      = 8;
  localparam int UART_ARB_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_LOAD      = 3'd1,
    ARB_START     = 3'd2,
    ARB_WAIT_BUSY = 3'd3,
    ARB_WAIT_DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first asserted req at or after ptr,
// wrapping through the lower indices. Reusable by any arbiter.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of uart_tx.
// Optional LOAD stall timeout: define UART_TX_ARBITER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no owner; pick next requester round-robin
// LOAD      | owner granted; wait for its next byte
// START     | raise tx_write
// WAIT_BUSY | hold tx_write until uart_tx reports busy
// WAIT_DONE | wait for the byte to finish; release on last
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = UART_ARB_NUM_REQ,
  parameter int DATA_BITS      = UART_ARB_DATA_BITS,
  parameter int TIMEOUT_CYCLES = UART_ARB_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_byte,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         tx_write,
  output logic [DATA_BITS-1:0]         tx_byte,
  input  logic                         tx_busy,
  output logic                         arb_busy,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e          state, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [IDX_W-1:0]    gidx, gidx_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt, ptr_after_g;
  logic                tx_write_nxt;
  logic [DATA_BITS-1:0] tx_byte_nxt;
  logic                last_q, last_q_nxt;
  logic                timeout_err_nxt;
  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                accept;
  logic                to_hit;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req      (req_valid),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign accept      = (state == ARB_LOAD) && req_valid[gidx];
  assign req_ready   = (state == ARB_LOAD) ? (grant & req_valid) : '0;
  assign arb_busy    = (state != ARB_IDLE);
  assign ptr_after_g = (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Counts LOAD cycles without an accept; restarts on every LOAD entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state_nxt == ARB_LOAD && state != ARB_LOAD) begin
      to_cnt <= '0;
    end else if (state == ARB_LOAD && !accept) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == ARB_LOAD) && !accept && (to_cnt == TO_W'(TIMEOUT_CYCLES-1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      gidx        <= '0;
      ptr         <= '0;
      tx_write    <= 1'b0;
      tx_byte     <= '0;
      last_q      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      gidx        <= gidx_nxt;
      ptr         <= ptr_nxt;
      tx_write    <= tx_write_nxt;
      tx_byte     <= tx_byte_nxt;
      last_q      <= last_q_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    gidx_nxt        = gidx;
    ptr_nxt         = ptr;
    tx_write_nxt    = tx_write;
    tx_byte_nxt     = tx_byte;
    last_q_nxt      = last_q;
    timeout_err_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|req_valid) begin
          grant_nxt = pick;
          gidx_nxt  = pick_idx;
          state_nxt = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        // An accept on the terminal timeout cycle takes priority.
        if (accept) begin
          tx_byte_nxt = req_byte[int'(gidx)*DATA_BITS +: DATA_BITS];
          last_q_nxt  = req_last[gidx];
          state_nxt   = ARB_START;
        end else if (to_hit) begin
          timeout_err_nxt = 1'b1;
          grant_nxt       = '0;
          ptr_nxt         = ptr_after_g;
          state_nxt       = ARB_IDLE;
        end
      end
      ARB_START: begin
        tx_write_nxt = 1'b1;
        state_nxt    = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (tx_busy) begin
          tx_write_nxt = 1'b0;
          state_nxt    = ARB_WAIT_DONE;
        end
      end
      ARB_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_nxt = '0;
            ptr_nxt   = ptr_after_g;
            state_nxt = ARB_IDLE;
          end else begin
            state_nxt = ARB_LOAD;
          end
        end
      end
      default: begin
        grant_nxt    = '0;
        tx_write_nxt = 1'b0;
        state_nxt    = ARB_IDLE;
      end
    endcase
  end

endmodule
